// File: rtl/rr_stream_mux_pkg.sv
// Shared mode encodings and width helper for the registered N-to-1 stream selector.
// Imported by the interface, the arbiter and the top level.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Number of bits needed to index n items; callers guarantee n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : stream_mux_pkg

// File: rtl/rr_stream_mux_if.sv
// N valid/ready source channels plus one registered output channel.
// The master side drives the sources and the output ready; the slave side is the mux.
interface rr_stream_mux_if
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 8,
  parameter int SEL_W = clog2(N_IN)
);

  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch
  );

endinterface : rr_stream_mux_if

// File: rtl/rr_stream_mux_arbiter.sv
// Rotate-priority arbiter: first requester found scanning ptr+1, ptr+2, ... modulo N.
// Purely combinational; a lone requester always wins regardless of ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  // One extra bit so ptr + k never overflows before the modulo fold (ptr < N, k <= N).
  logic [SW:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) begin
        idx = idx - (SW+1)'(N);
      end
      if (!gnt_vld && req[idx[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[SW-1:0];
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/rr_stream_mux.sv
// Registered N-to-1 stream selector, FIXED (sel) or ROUND_ROBIN; 1-cycle latency, 1 word/cycle.
// Output stall (out_valid && !out_ready) freezes the held word and drops every in_ready.
module rr_stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 8,
  parameter int SEL_W = clog2(N_IN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  rr_stream_mux_if.slave     bus
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;

  logic [N_IN-1:0]  fixed_req;
  logic [N_IN-1:0]  req;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;
  logic [N_IN-1:0]  in_ready;

  // Comparing sel against every legal index means an out-of-range sel simply matches nothing.
  always_comb begin
    fixed_req = '0;
    for (int i = 0; i < N_IN; i++) begin
      fixed_req[i] = bus.in_valid[i] && (sel == SEL_W'(i));
    end
  end

  assign req = (mode == MODE_RR) ? bus.in_valid : fixed_req;

  rr_arbiter #(
    .N  (N_IN),
    .SW (SEL_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign load_en = !out_valid_q || bus.out_ready;
  assign xfer    = load_en && gnt_vld;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = xfer;
        gnt_data    = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      if (mode == MODE_RR) begin
        ptr_d = gnt_idx;
      end
    end else if (load_en) begin
      // Drained (or already empty) with nothing new: data/ch keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= SEL_W'(N_IN - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule : rr_stream_mux

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: an 8-channel instance and a 5-channel instance share clk/reset.
module tb_rr_stream_mux;
  import stream_mux_pkg::*;

  logic clk;
  logic reset;
  logic       mode_a;
  logic [2:0] sel_a;
  logic       mode_b;
  logic [2:0] sel_b;

  int errors;
  int checks;

  rr_stream_mux_if #(.WIDTH(32), .N_IN(8)) bus_a ();
  rr_stream_mux_if #(.WIDTH(32), .N_IN(5)) bus_b ();

  rr_stream_mux #(.WIDTH(32), .N_IN(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .mode  (mode_a),
    .sel   (sel_a),
    .bus   (bus_a)
  );

  rr_stream_mux #(.WIDTH(32), .N_IN(5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .mode  (mode_b),
    .sel   (sel_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out_a(input string tag, input logic v, input logic [2:0] ch);
    chk({tag, ".valid"}, 64'(bus_a.out_valid), 64'(v));
    chk({tag, ".ch"},    64'(bus_a.out_ch),    64'(ch));
    chk({tag, ".data"},  64'(bus_a.out_data),  64'h0A0 + 64'(ch));
  endtask

  task automatic chk_out_b(input string tag, input logic v, input logic [2:0] ch);
    chk({tag, ".valid"}, 64'(bus_b.out_valid), 64'(v));
    chk({tag, ".ch"},    64'(bus_b.out_ch),    64'(ch));
    chk({tag, ".data"},  64'(bus_b.out_data),  64'h0B0 + 64'(ch));
  endtask

  initial begin
    logic [2:0] wrap_seq [4];
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    mode_a = 1'b0;
    sel_a  = 3'd0;
    mode_b = 1'b0;
    sel_b  = 3'd0;
    bus_a.in_valid  = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = '0;
    bus_b.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_a.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    for (int i = 0; i < 5; i++) bus_b.in_data[i*32 +: 32] = 32'hB0 + 32'(i);

    // Reset state
    tick;
    tick;
    chk("rst.valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst.data",  64'(bus_a.out_data),  64'd0);
    chk("rst.ch",    64'(bus_a.out_ch),    64'd0);
    chk("rst.rdy",   64'(bus_a.in_ready),  64'd0);
    reset = 1'b0;

    // FIXED, sel=5, everyone valid
    mode_a = MODE_FIXED;
    sel_a  = 3'd5;
    bus_a.in_valid  = 8'hFF;
    bus_a.out_ready = 1'b1;
    #1;
    chk("fix.rdy0", 64'(bus_a.in_ready), 64'h20);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk_out_a("fix.out", 1'b1, 3'd5);
      chk("fix.rdy", 64'(bus_a.in_ready), 64'h20);
    end

    // ROUND_ROBIN, all valid: pointer still at 7 so 0 goes first
    mode_a = MODE_RR;
    #1;
    for (int k = 0; k < 9; k++) begin
      chk("rr.rdy", 64'(bus_a.in_ready), 64'd1 << (k % 8));
      tick;
      chk_out_a("rr.out", 1'b1, 3'(k % 8));
    end

    // Backpressure holding ch0
    bus_a.out_ready = 1'b0;
    #1;
    chk("bp.rdy0", 64'(bus_a.in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk_out_a("bp.hold", 1'b1, 3'd0);
      chk("bp.rdy", 64'(bus_a.in_ready), 64'd0);
    end
    bus_a.out_ready = 1'b1;
    #1;
    chk("bp.rel.rdy", 64'(bus_a.in_ready), 64'h02);
    tick;
    chk_out_a("bp.rel.out", 1'b1, 3'd1);

    // Single requester ch3: granted every cycle without a bubble
    bus_a.in_valid = 8'h08;
    #1;
    chk("one.rdy0", 64'(bus_a.in_ready), 64'h08);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk_out_a("one.out", 1'b1, 3'd3);
      chk("one.rdy", 64'(bus_a.in_ready), 64'h08);
    end

    // Move pointer to 6, then ch7/ch2 alternate across the wrap
    bus_a.in_valid = 8'h40;
    tick;
    chk_out_a("ptr6.out", 1'b1, 3'd6);
    bus_a.in_valid = 8'h84;
    wrap_seq[0] = 3'd7;
    wrap_seq[1] = 3'd2;
    wrap_seq[2] = 3'd7;
    wrap_seq[3] = 3'd2;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("wrap.rdy", 64'(bus_a.in_ready), 64'd1 << wrap_seq[k]);
      tick;
      chk_out_a("wrap.out", 1'b1, wrap_seq[k]);
    end

    // Drain with no requesters: valid falls, data/ch hold
    bus_a.in_valid = 8'h00;
    #1;
    chk("drain.rdy", 64'(bus_a.in_ready), 64'd0);
    tick;
    chk_out_a("drain.out", 1'b0, 3'd2);

    // Reset mid-stream with a held word
    bus_a.in_valid = 8'hFF;
    tick;
    chk_out_a("pre.rst", 1'b1, 3'd3);
    bus_a.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mrst.valid", 64'(bus_a.out_valid), 64'd0);
    chk("mrst.data",  64'(bus_a.out_data),  64'd0);
    chk("mrst.ch",    64'(bus_a.out_ch),    64'd0);
    tick;
    reset = 1'b0;
    bus_a.out_ready = 1'b1;
    #1;
    chk("post.rst.rdy", 64'(bus_a.in_ready), 64'h01);
    tick;
    chk_out_a("post.rst.out", 1'b1, 3'd0);
    bus_a.in_valid = 8'h00;

    // N_IN=5 instance: FIXED, then out-of-range sel
    mode_b = MODE_FIXED;
    sel_b  = 3'd2;
    bus_b.in_valid  = 5'h1F;
    bus_b.out_ready = 1'b1;
    #1;
    chk("b.fix.rdy", 64'(bus_b.in_ready), 64'h04);
    tick;
    chk_out_b("b.fix.out", 1'b1, 3'd2);
    sel_b = 3'd6;
    #1;
    chk("b.range.rdy", 64'(bus_b.in_ready), 64'd0);
    tick;
    chk_out_b("b.range.out", 1'b0, 3'd2);
    chk("b.range.rdy2", 64'(bus_b.in_ready), 64'd0);

    // Mode switch while the held word is stalled
    sel_b = 3'd1;
    #1;
    chk("b.sel1.rdy", 64'(bus_b.in_ready), 64'h02);
    tick;
    chk_out_b("b.sel1.out", 1'b1, 3'd1);
    bus_b.out_ready = 1'b0;
    mode_b = MODE_RR;
    #1;
    chk("b.sw.rdy", 64'(bus_b.in_ready), 64'd0);
    tick;
    chk_out_b("b.sw.hold", 1'b1, 3'd1);
    bus_b.out_ready = 1'b1;
    #1;
    // FIXED grants never moved the pointer, so it is still at N_IN-1 = 4
    chk("b.rr.rdy", 64'(bus_b.in_ready), 64'h01);
    tick;
    chk_out_b("b.rr.out", 1'b1, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rr_stream_mux
